// File: rtl/job_loader.sv
// job_loader: byte-stream job loader and result collector for the miner.
// A job arrives as BLOCK_BYTES header bytes (first byte lands in the MSB
// byte of miner_data) followed by one target byte. The loader then arms the
// miner for one cycle, runs it until it reports finished, and returns the
// nonce and elapsed RUN cycle count as a result.
// Optional feature: define JOB_TIMEOUT_EN to abort RUN after TIMEOUT_CYCLES
// cycles and report res_timeout=1.
// Handshakes: a byte transfers on a cycle with in_valid & in_ready, a result
// is consumed on a cycle with res_valid & res_ready; valid never waits on
// ready, and all outputs come from registers.
module job_loader #(
    parameter int BYTE           = 8,
    parameter int BLOCK_BYTES    = 12,
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic [BYTE-1:0]             in_byte,
    output logic                        in_ready,
    input  logic                        miner_finished,
    input  logic [31:0]                 miner_nonce,
    output logic [BYTE*BLOCK_BYTES-1:0] miner_data,
    output logic [7:0]                  miner_target,
    output logic                        miner_run,
    output logic                        busy,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [31:0]                 res_nonce,
    output logic [CNT_W-1:0]            res_cycles,
    output logic                        res_timeout,
    output logic [1:0]                  dbg_state
);

    localparam logic [1:0] ST_LOAD   = 2'd0;
    localparam logic [1:0] ST_ARM    = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_REPORT = 2'd3;

    localparam int IDX_W = $clog2(BLOCK_BYTES + 1);

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    logic             load_xfer;
    logic             last_xfer;
    logic             fin_hit;
    logic             to_hit;

    // Output decodes of the state register only, so no input reaches an output.
    assign in_ready  = (state == ST_LOAD);
    assign miner_run = (state == ST_RUN);
    assign busy      = (state == ST_ARM) || (state == ST_RUN);
    assign res_valid = (state == ST_REPORT);
    assign dbg_state = state;

    // Transfer and RUN-exit conditions; finished is ignored while cnt is 0 (first RUN cycle).
    always_comb begin
        load_xfer = (state == ST_LOAD) && in_valid;
        last_xfer = load_xfer && (idx == IDX_W'(BLOCK_BYTES));
        fin_hit   = (state == ST_RUN) && miner_finished && (cnt != '0);
`ifdef JOB_TIMEOUT_EN
        to_hit    = (state == ST_RUN) && !fin_hit && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
        to_hit    = 1'b0;
`endif
    end

    // Control FSM and byte index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_LOAD;
            idx   <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (last_xfer) begin
                        state <= ST_ARM;
                        idx   <= '0;
                    end else if (load_xfer) begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_ARM:    state <= ST_RUN;
                ST_RUN:    if (fin_hit || to_hit) state <= ST_REPORT;
                ST_REPORT: if (res_ready) state <= ST_LOAD;
                default:   state <= ST_LOAD;
            endcase
        end
    end

    // Job assembly: header bytes fill from the MSB down, then the target byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            miner_data   <= '0;
            miner_target <= '0;
        end else if (last_xfer) begin
            miner_target <= 8'(in_byte);
        end else if (load_xfer) begin
            for (int k = 0; k < BLOCK_BYTES; k++) begin
                if (idx == IDX_W'(k)) begin
                    miner_data[BYTE*(BLOCK_BYTES-k)-1 -: BYTE] <= in_byte;
                end
            end
        end
    end

    // RUN cycle counter: cleared in ARM, saturating increment in RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (state == ST_ARM) begin
            cnt <= '0;
        end else if ((state == ST_RUN) && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Result capture on finished (or timeout); held stable through REPORT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_nonce  <= '0;
            res_cycles <= '0;
        end else if (fin_hit) begin
            res_nonce  <= miner_nonce;
            res_cycles <= cnt;
        end else if (to_hit) begin
            res_nonce  <= miner_nonce;
            res_cycles <= CNT_W'(TIMEOUT_CYCLES);
        end
    end

`ifdef JOB_TIMEOUT_EN
    // Timeout flag: set only when RUN ends without a valid finished.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_timeout <= 1'b0;
        end else if (fin_hit) begin
            res_timeout <= 1'b0;
        end else if (to_hit) begin
            res_timeout <= 1'b1;
        end
    end
`else
    assign res_timeout = 1'b0;
`endif

endmodule

// File: doc/job_loader.md
Name: job_loader

Overview:
- Upstream feeder for the mining system. Receives a job as a byte stream with a valid/ready handshake: 12 block-header bytes followed by 1 target byte.
- Assembles the job into the 96-bit block and 8-bit target buses, then releases the miner with a run enable and waits for its finished flag.
- Captures the winning nonce and the elapsed cycle count, and presents them as a result with a valid/ready handshake.

Parameters:
- BYTE, 8, bits per stream byte and per block byte.
- BLOCK_BYTES, 12, header bytes per job; miner_data width is BYTE*BLOCK_BYTES.
- CNT_W, 32, width of the mining-cycle counter.
- TIMEOUT_CYCLES, 1024, abort threshold in RUN cycles; used only with JOB_TIMEOUT_EN.

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- in_valid  in  1  stream byte valid.
- in_byte  in  BYTE  stream byte.
- in_ready  out  1  loader can accept a byte.
- miner_finished  in  1  finished flag from the miner.
- miner_nonce  in  32  nonce output from the miner.
- miner_data  out  BYTE*BLOCK_BYTES  assembled block header to the miner.
- miner_target  out  8  target to the miner.
- miner_run  out  1  1 = miner enabled; 0 = miner held in reset (integration adapts polarity).
- busy  out  1  high in ARM and RUN.
- res_valid  out  1  result available.
- res_ready  in  1  result consumer ready.
- res_nonce  out  32  captured nonce.
- res_cycles  out  CNT_W  RUN cycles elapsed until finished.
- res_timeout  out  1  result produced by timeout rather than by finished.

Behaviour:
Reset (reset=0, asynchronous):
- State LOAD, byte index 0.
- miner_data=0, miner_target=0, miner_run=0, busy=0.
- res_valid=0, res_nonce=0, res_cycles=0, res_timeout=0, cycle counter 0.
- Reset asserted mid-job discards everything; no partial result is emitted.

Handshake:
- A transfer occurs on a cycle with in_valid & in_ready.
- A result is consumed on a cycle with res_valid & res_ready.
- Outputs are registered; no combinational path from any input to any output.

States:
- LOAD:
  - in_ready=1.
  - Transfers k=0..BLOCK_BYTES-1 write miner_data[BYTE*(BLOCK_BYTES-k)-1 -: BYTE], so the first byte lands in the MSB byte.
  - Transfer k=BLOCK_BYTES writes miner_target; the next state is ARM and the index resets to 0.
  - in_valid=0 stalls the load indefinitely; the index holds.
  - Extra bytes arriving outside LOAD are not accepted (in_ready=0).
- ARM:
  - Exactly 1 cycle. miner_run=0, busy=1, cycle counter cleared.
  - Guarantees miner_data/miner_target are stable for at least one cycle before the run enable rises.
  - Next state is RUN.
- RUN:
  - miner_run=1, busy=1. The counter increments each cycle and saturates at all-ones.
  - miner_finished is ignored in the first RUN cycle (stale flag from the previous job).
  - From the second cycle on, miner_finished=1 captures res_nonce=miner_nonce, res_cycles=counter, res_timeout=0, and moves to REPORT.
- REPORT:
  - miner_run=0, busy=0, res_valid=1. The result holds stable until consumed.
  - On res_ready, res_valid falls next cycle and the state returns to LOAD.
  - If res_ready is already high on REPORT entry, the result is consumed in the first REPORT cycle; res_valid is high for exactly 1 cycle.

Other rules:
- miner_finished outside RUN is ignored.
- miner_data/miner_target keep their values outside LOAD byte writes, so the last job is visible until overwritten.
- The latency from the last target byte accepted to miner_run=1 is 2 cycles: ARM, then the first RUN cycle.

Optional Feature:
- Macro JOB_TIMEOUT_EN.
- Defined: in RUN, when the counter reaches TIMEOUT_CYCLES without a valid finished, the block moves to REPORT with res_timeout=1, res_nonce=current miner_nonce, res_cycles=TIMEOUT_CYCLES. If finished and the timeout occur in the same cycle, finished wins (res_timeout=0).
- Not defined: no timeout. res_timeout is a constant 0 and RUN exits only on finished.

Test Plan:
- Stream bytes 0x01..0x0C then target 0x10, in_valid held high -> in_ready low after the 13th byte; miner_data=0x0102030405060708090A0B0C; miner_target=0x10; miner_run rises 2 cycles later.
- Miner model asserts finished with nonce 0x0000002A on RUN cycle 37 -> res_valid=1, res_nonce=0x2A, res_cycles=36, res_timeout=0, miner_run=0; result holds through 5 cycles of res_ready=0 and clears 1 cycle after res_ready=1.
- in_valid toggling 1/0 every cycle during load -> the 13 bytes are still assembled in order; the ARM entry timing is relative to the 13th accept.
- miner_finished=1 in the first RUN cycle and also during LOAD -> both ignored; no result produced.
- Reset pulsed low after 6 bytes, then a full new job 0xFF..0xF4 with target 0x01 -> miner_data=0xFFFEFDFCFBFAF9F8F7F6F5F4; no stale bytes remain.
- With JOB_TIMEOUT_EN and TIMEOUT_CYCLES=16, no finished -> after 16 RUN cycles res_valid=1, res_timeout=1, res_cycles=16; a finished arriving in that same cycle -> res_timeout=0.
